// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared EX-stage op codes, bus widths, FSM state codes and
// op-classification helpers for the load/store unit.
package mem_access_pkg;

    localparam int unsigned ALU_OP_W   = 8;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned SEL_W      = 4;

    // EX-stage operation codes
    localparam logic [ALU_OP_W-1:0] EXE_NOP_OP = 8'b0000_0000;
    localparam logic [ALU_OP_W-1:0] EXE_ADD_OP = 8'b0010_0000;
    localparam logic [ALU_OP_W-1:0] EXE_SUB_OP = 8'b0010_0010;
    localparam logic [ALU_OP_W-1:0] EXE_AND_OP = 8'b0010_0100;
    localparam logic [ALU_OP_W-1:0] EXE_OR_OP  = 8'b0010_0101;
    localparam logic [ALU_OP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [ALU_OP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [ALU_OP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [ALU_OP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [ALU_OP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [ALU_OP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [ALU_OP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [ALU_OP_W-1:0] EXE_SW_OP  = 8'b1110_1011;

    // Access FSM state codes
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    typedef enum logic [1:0] {
        SIZE_NONE,
        SIZE_BYTE,
        SIZE_HALF,
        SIZE_WORD
    } mem_size_e;

    function automatic mem_size_e op_size(input logic [ALU_OP_W-1:0] op);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return SIZE_BYTE;
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return SIZE_HALF;
            EXE_LW_OP, EXE_SW_OP:             return SIZE_WORD;
            default:                          return SIZE_NONE;
        endcase
    endfunction

    function automatic logic op_is_load(input logic [ALU_OP_W-1:0] op);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP: return 1'b1;
            default:                                                 return 1'b0;
        endcase
    endfunction

    function automatic logic op_is_mem(input logic [ALU_OP_W-1:0] op);
        return op_size(op) != SIZE_NONE;
    endfunction

    // Halfword needs addr[0]=0, word needs addr[1:0]=0
    function automatic logic op_misaligned(input logic [ALU_OP_W-1:0] op,
                                           input logic [1:0]          addr_lo);
        case (op_size(op))
            SIZE_HALF: return addr_lo[0];
            SIZE_WORD: return addr_lo != 2'b00;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: big-endian byte-lane selection, store-data replication and
// load-data extraction/extension. Purely combinational.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [ALU_OP_W-1:0] op,
    input  logic [1:0]          addr_lo,
    input  logic [DATA_W-1:0]   store_data,
    input  logic [DATA_W-1:0]   rdata,
    output logic [SEL_W-1:0]    sel,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   load_data
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Pick the addressed byte/halfword; lane 0 is the most significant byte
    always_comb begin
        case (addr_lo)
            2'd0:    rd_byte = rdata[31:24];
            2'd1:    rd_byte = rdata[23:16];
            2'd2:    rd_byte = rdata[15:8];
            default: rd_byte = rdata[7:0];
        endcase
        rd_half = addr_lo[1] ? rdata[15:0] : rdata[31:16];
    end

    // Lane enables and store data replicated across every lane
    always_comb begin
        sel   = '0;
        wdata = '0;
        case (op_size(op))
            SIZE_BYTE: begin
                sel   = 4'b1000 >> addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            SIZE_HALF: begin
                sel   = addr_lo[1] ? 4'b0011 : 4'b1100;
                wdata = {2{store_data[15:0]}};
            end
            SIZE_WORD: begin
                sel   = '1;
                wdata = store_data;
            end
            default: ;
        endcase
    end

    // Load result with sign or zero extension
    always_comb begin
        load_data = '0;
        case (op)
            EXE_LB_OP:  load_data = {{24{rd_byte[7]}}, rd_byte};
            EXE_LBU_OP: load_data = {24'd0, rd_byte};
            EXE_LH_OP:  load_data = {{16{rd_half[15]}}, rd_half};
            EXE_LHU_OP: load_data = {16'd0, rd_half};
            EXE_LW_OP:  load_data = rdata;
            default:    load_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: MEM-stage load/store unit. Non-memory ops pass straight to
// writeback; memory ops run IDLE -> BUSY -> DONE on the bus with a timeout.
// Optional macro MEM_ALIGN_CHECK_EN adds excp_misalign_o and skips the bus
// for misaligned halfword/word accesses.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ALU_OP_W-1:0]   aluOp_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [DATA_W-1:0]     reg2_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [DATA_W-1:0]     wdata_o,
    output logic                  stallreq_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [ADDR_W-1:0]     bus_addr_o,
    output logic [SEL_W-1:0]      bus_sel_o,
    output logic [DATA_W-1:0]     bus_wdata_o,
    input  logic [DATA_W-1:0]     bus_rdata_i,
    input  logic                  bus_ack_i,
    output logic                  bus_err_o
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic                  excp_misalign_o
`endif
);

    localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic [ALU_OP_W-1:0]   op_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     sdata_q;
    logic [REG_ADDR_W-1:0] wd_q;
    logic                  done_wreg;
    logic [DATA_W-1:0]     done_wdata;
    logic                  bus_err_q;
    logic [SEL_W-1:0]      lane_sel;
    logic [DATA_W-1:0]     lane_wdata;
    logic [DATA_W-1:0]     lane_load;

`ifdef MEM_ALIGN_CHECK_EN
    logic misalign_now;
    logic misalign_q;
    assign misalign_now    = op_misaligned(aluOp_i, mem_addr_i[1:0]);
    assign excp_misalign_o = misalign_q;
`endif

    mem_lane_align u_lane (
        .op         (op_q),
        .addr_lo    (addr_q[1:0]),
        .store_data (sdata_q),
        .rdata      (bus_rdata_i),
        .sel        (lane_sel),
        .wdata      (lane_wdata),
        .load_data  (lane_load)
    );

    assign bus_err_o = bus_err_q;

    // Access FSM, BUSY timeout counter and operand/result latches
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            op_q       <= '0;
            addr_q     <= '0;
            sdata_q    <= '0;
            wd_q       <= '0;
            done_wreg  <= 1'b0;
            done_wdata <= '0;
            bus_err_q  <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            bus_err_q <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (op_is_mem(aluOp_i)) begin
                        op_q       <= aluOp_i;
                        addr_q     <= mem_addr_i;
                        sdata_q    <= reg2_i;
                        wd_q       <= wd_i;
                        cnt        <= '0;
                        done_wreg  <= 1'b0;
                        done_wdata <= '0;
`ifdef MEM_ALIGN_CHECK_EN
                        state      <= misalign_now ? ST_DONE : ST_BUSY;
                        misalign_q <= misalign_now;
`else
                        state      <= ST_BUSY;
`endif
                    end
                end
                ST_BUSY: begin
                    if (bus_ack_i) begin
                        state      <= ST_DONE;
                        done_wreg  <= op_is_load(op_q);
                        done_wdata <= op_is_load(op_q) ? lane_load : '0;
                    end else if (cnt == CNT_LAST) begin
                        state     <= ST_DONE;
                        bus_err_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Writeback, stall and bus outputs; everything forced low while in reset
    always_comb begin
        wd_o        = '0;
        wreg_o      = 1'b0;
        wdata_o     = '0;
        stallreq_o  = 1'b0;
        bus_req_o   = 1'b0;
        bus_we_o    = 1'b0;
        bus_addr_o  = '0;
        bus_sel_o   = '0;
        bus_wdata_o = '0;
        if (rst) begin
            case (state)
                ST_IDLE: begin
                    if (op_is_mem(aluOp_i)) begin
                        stallreq_o = 1'b1;
                    end else begin
                        wd_o    = wd_i;
                        wreg_o  = wreg_i;
                        wdata_o = wdata_i;
                    end
                end
                ST_BUSY: begin
                    stallreq_o  = 1'b1;
                    bus_req_o   = 1'b1;
                    bus_we_o    = !op_is_load(op_q);
                    bus_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
                    bus_sel_o   = lane_sel;
                    bus_wdata_o = lane_wdata;
                end
                ST_DONE: begin
                    wd_o    = wd_q;
                    wreg_o  = done_wreg;
                    wdata_o = done_wdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized and directed checks of mem_access against a
// behavioural model of the load/store rules. Honours MEM_ALIGN_CHECK_EN.
module tb_mem_access;
    import mem_access_pkg::*;

    localparam int unsigned TO = 4;

    logic        clk;
    logic        rst;
    logic [7:0]  aluOp_i;
    logic [31:0] mem_addr_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic        bus_err_o;
`ifdef MEM_ALIGN_CHECK_EN
    logic        excp_misalign_o;
`endif

    int n_checks;
    int n_errors;

    logic [7:0] mem_ops [8];

    mem_access #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .aluOp_i     (aluOp_i),
        .mem_addr_i  (mem_addr_i),
        .reg2_i      (reg2_i),
        .wd_i        (wd_i),
        .wreg_i      (wreg_i),
        .wdata_i     (wdata_i),
        .wd_o        (wd_o),
        .wreg_o      (wreg_o),
        .wdata_o     (wdata_o),
        .stallreq_o  (stallreq_o),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_sel_o   (bus_sel_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_rdata_i (bus_rdata_i),
        .bus_ack_i   (bus_ack_i),
        .bus_err_o   (bus_err_o)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .excp_misalign_o (excp_misalign_o)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int unsigned m_bytes(input logic [7:0] op);
        if (op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_SB_OP) return 1;
        if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) return 2;
        if (op == EXE_LW_OP || op == EXE_SW_OP) return 4;
        return 0;
    endfunction

    function automatic bit m_is_load(input logic [7:0] op);
        return op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_LH_OP ||
               op == EXE_LHU_OP || op == EXE_LW_OP;
    endfunction

    function automatic bit m_misaligned(input logic [7:0] op, input logic [31:0] addr);
`ifdef MEM_ALIGN_CHECK_EN
        int unsigned n = m_bytes(op);
        return n > 1 && (addr % n) != 0;
`else
        return (op == 8'hxx) && (addr == 32'hxxxxxxxx);
`endif
    endfunction

    function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] addr,
                                           input logic [31:0] rd);
        int unsigned bi = addr % 4;
        int unsigned hi = bi / 2;
        logic [31:0] b = (rd >> (8 * (3 - bi))) & 32'hFF;
        logic [31:0] h = (rd >> (16 * (1 - hi))) & 32'hFFFF;
        if (op == EXE_LB_OP)  return (b >= 32'd128)   ? b - 32'd256   : b;
        if (op == EXE_LBU_OP) return b;
        if (op == EXE_LH_OP)  return (h >= 32'd32768) ? h - 32'd65536 : h;
        if (op == EXE_LHU_OP) return h;
        if (op == EXE_LW_OP)  return rd;
        return 32'd0;
    endfunction

    function automatic logic [3:0] m_sel(input logic [7:0] op, input logic [31:0] addr);
        int unsigned bi = addr % 4;
        case (m_bytes(op))
            1:       return 4'(8 >> bi);
            2:       return 4'(12 >> (2 * (bi / 2)));
            default: return 4'd15;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] d);
        case (m_bytes(op))
            1:       return (d & 32'hFF) * 32'h0101_0101;
            2:       return (d & 32'hFFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    // ---------------- stimulus tasks ----------------
    // Starts and ends with the DUT idle, just after a falling edge.
    task automatic do_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] rdata, input int unsigned delay);
        logic [4:0]  wd      = 5'($urandom);
        bit          mis     = m_misaligned(op, addr);
        bit          ld      = m_is_load(op);
        bit          acked   = 1'b0;
        int unsigned stall_n = 0;
        int unsigned exp_busy = (delay < TO) ? delay + 1 : TO;

        aluOp_i     = op;
        mem_addr_i  = addr;
        reg2_i      = sdata;
        wd_i        = wd;
        wreg_i      = 1'($urandom);
        wdata_i     = $urandom;
        bus_ack_i   = 1'($urandom);
        bus_rdata_i = $urandom;
        #1;
        check("idle_stall", stallreq_o, 1);
        check("idle_req", bus_req_o, 0);
        check("idle_wreg", wreg_o, 0);
        stall_n += stallreq_o;

        if (!mis) begin
            for (int unsigned n = 0; n < TO; n++) begin
                @(negedge clk);
                bus_ack_i   = (n == delay);
                bus_rdata_i = (n == delay) ? rdata : $urandom;
                #1;
                check("busy_req", bus_req_o, 1);
                check("busy_we", bus_we_o, !ld);
                check("busy_addr", bus_addr_o, addr - (addr % 4));
                check("busy_sel", bus_sel_o, m_sel(op, addr));
                check("busy_wdata", bus_wdata_o, m_wdata(op, sdata));
                stall_n += stallreq_o;
                if (n == delay) begin
                    acked = 1'b1;
                    break;
                end
            end
        end

        @(negedge clk);
        aluOp_i     = EXE_ADD_OP;
        wd_i        = 5'($urandom);
        wreg_i      = 1'b1;
        wdata_i     = $urandom;
        bus_ack_i   = 1'($urandom);
        bus_rdata_i = $urandom;
        #1;
        check("done_stall", stallreq_o, 0);
        check("done_req", bus_req_o, 0);
        check("done_wd", wd_o, wd);
        check("done_wreg", wreg_o, ld && acked);
        check("done_wdata", wdata_o, (ld && acked) ? m_load(op, addr, rdata) : 32'd0);
        check("done_err", bus_err_o, !mis && !acked);
        check("stall_cycles", stall_n, mis ? 1 : 1 + exp_busy);
`ifdef MEM_ALIGN_CHECK_EN
        check("done_misalign", excp_misalign_o, mis);
`endif

        @(negedge clk);
        bus_ack_i = 1'b0;
        #1;
        check("after_err", bus_err_o, 0);
        check("after_pass_wd", wd_o, wd_i);
        check("after_stall", stallreq_o, 0);
`ifdef MEM_ALIGN_CHECK_EN
        check("after_misalign", excp_misalign_o, 0);
`endif
    endtask

    task automatic do_alu();
        logic [7:0] op = 8'($urandom);
        if (m_bytes(op) != 0) op = EXE_OR_OP;
        aluOp_i     = op;
        mem_addr_i  = $urandom;
        reg2_i      = $urandom;
        wd_i        = 5'($urandom);
        wreg_i      = 1'($urandom);
        wdata_i     = $urandom;
        bus_ack_i   = 1'($urandom);
        #1;
        check("alu_wd", wd_o, wd_i);
        check("alu_wreg", wreg_o, wreg_i);
        check("alu_wdata", wdata_o, wdata_i);
        check("alu_stall", stallreq_o, 0);
        check("alu_req", bus_req_o, 0);
        @(negedge clk);
    endtask

    task automatic do_reset_mid_busy();
        aluOp_i    = EXE_LW_OP;
        mem_addr_i = 32'h300;
        wd_i       = 5'd9;
        bus_ack_i  = 1'b0;
        @(negedge clk);
        #1 check("rb_busy1_req", bus_req_o, 1);
        @(negedge clk);
        #1 check("rb_busy2_req", bus_req_o, 1);
        rst = 1'b0;
        #1;
        check("rb_req", bus_req_o, 0);
        check("rb_stall", stallreq_o, 0);
        check("rb_err", bus_err_o, 0);
        @(negedge clk);
        aluOp_i = EXE_ADD_OP;
        wd_i    = 5'd17;
        wreg_i  = 1'b1;
        wdata_i = 32'hCAFE_0001;
        #1;
        check("rst_wd", wd_o, 0);
        check("rst_wreg", wreg_o, 0);
        check("rst_err", bus_err_o, 0);
        rst = 1'b1;
        #1;
        check("post_rst_wd", wd_o, 5'd17);
        check("post_rst_wreg", wreg_o, 1);
        check("post_rst_wdata", wdata_o, 32'hCAFE_0001);
        check("post_rst_stall", stallreq_o, 0);
        @(negedge clk);
        #1;
        check("post_rst_req", bus_req_o, 0);
        check("post_rst_err", bus_err_o, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        mem_ops = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP,
                    EXE_LW_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
        rst         = 1'b1;
        aluOp_i     = EXE_ADD_OP;
        mem_addr_i  = '0;
        reg2_i      = '0;
        wd_i        = 5'd7;
        wreg_i      = 1'b1;
        wdata_i     = 32'h55;
        bus_rdata_i = '0;
        bus_ack_i   = 1'b0;
        #1 rst = 1'b0;
        #2;
        check("reset_wd", wd_o, 0);
        check("reset_wreg", wreg_o, 0);
        check("reset_wdata", wdata_o, 0);
        check("reset_stall", stallreq_o, 0);
        check("reset_req", bus_req_o, 0);
        check("reset_err", bus_err_o, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        do_alu();
        do_mem(EXE_LW_OP,  32'h100, $urandom, 32'hDEAD_BEEF, 0);
        do_mem(EXE_LB_OP,  32'h103, $urandom, 32'h0000_00F0, 0);
        do_mem(EXE_LBU_OP, 32'h103, $urandom, 32'h0000_00F0, 0);
        do_mem(EXE_SH_OP,  32'h102, 32'h1234_ABCD, $urandom, 1);
        do_mem(EXE_LW_OP,  32'h200, $urandom, $urandom, 100);
        do_mem(EXE_LH_OP,  32'h202, $urandom, 32'h8001_7FFF, TO - 1);
        do_mem(EXE_LW_OP,  32'h101, $urandom, 32'h0102_0304, 0);
        do_mem(EXE_SB_OP,  32'h3FD, 32'h0000_00A5, $urandom, 2);
        do_reset_mid_busy();

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0)
                do_alu();
            else
                do_mem(mem_ops[$urandom_range(0, 7)], $urandom, $urandom, $urandom,
                       $urandom_range(0, 5));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
